// File: rtl/multicycle_alu_if.sv
// Request/response bundle between the pipeline control and the execute-stage ALU.
// The master issues ops and watches the handshake; the slave is the ALU.
interface multicycle_alu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       alucontrol;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;
    logic             done;
    logic             illegal;

    modport master (
        output start, alucontrol, a, b,
        input  result, zero, busy, done, illegal
    );

    modport slave (
        input  start, alucontrol, a, b,
        output result, zero, busy, done, illegal
    );
endinterface

// File: rtl/multicycle_alu.sv
// Execute-stage ALU: logic/add/sub/slt finish in one cycle, MUL and DIV iterate
// one bit per cycle behind a start/busy/done handshake.
module multicycle_alu #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    multicycle_alu_if.slave    bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b1010;
    localparam logic [3:0] OP_SLT = 4'b1011;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_DIV = 4'b0101;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? (~x + 1'b1) : x;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             illegal_q, illegal_d;

    // Shared engine: acc is product accumulator / partial remainder,
    // x is multiplier / dividend-then-quotient, y is multiplicand / divisor.
    logic             mul_q, mul_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;

    logic signed [WIDTH-1:0] a_s, b_s;
    logic [WIDTH-1:0] acc_step, x_step, y_step, final_res, quick_res;
    logic [WIDTH:0]   rem_sh, diff;
    logic             quick;

    assign a_s = bus.a;
    assign b_s = bus.b;

    always_comb begin
        rem_sh = {acc_q, x_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, y_q};
        if (mul_q) begin
            acc_step = acc_q + (x_q[0] ? y_q : '0);
            x_step   = x_q >> 1;
            y_step   = y_q << 1;
        end else if (!diff[WIDTH]) begin
            acc_step = diff[WIDTH-1:0];
            x_step   = {x_q[WIDTH-2:0], 1'b1};
            y_step   = y_q;
        end else begin
            acc_step = rem_sh[WIDTH-1:0];
            x_step   = {x_q[WIDTH-2:0], 1'b0};
            y_step   = y_q;
        end
        final_res = mul_q ? acc_step : cond_neg(x_step, neg_q);
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        result_d  = result_q;
        zero_d    = zero_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        mul_d     = mul_q;
        neg_d     = neg_q;
        acc_d     = acc_q;
        x_d       = x_q;
        y_d       = y_q;
        quick     = 1'b0;
        quick_res = '0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    quick = 1'b1;
                    case (bus.alucontrol)
                        OP_AND: quick_res = bus.a & bus.b;
                        OP_OR:  quick_res = bus.a | bus.b;
                        OP_ADD: quick_res = bus.a + bus.b;
                        OP_SUB: quick_res = bus.a - bus.b;
                        OP_SLT: quick_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
                        OP_MUL: begin
                            quick   = 1'b0;
                            mul_d   = 1'b1;
                            acc_d   = '0;
                            x_d     = bus.a;
                            y_d     = bus.b;
                            count_d = CNT_LOAD;
                            state_d = CALC;
                        end
                        OP_DIV: begin
                            if (bus.b == '0) begin
                                quick_res = '1;
                            end else begin
                                quick   = 1'b0;
                                mul_d   = 1'b0;
                                neg_d   = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                                acc_d   = '0;
                                x_d     = abs_val(bus.a);
                                y_d     = abs_val(bus.b);
                                count_d = CNT_LOAD;
                                state_d = CALC;
                            end
                        end
                        default: illegal_d = 1'b1;
                    endcase
                    if (quick) begin
                        result_d = quick_res;
                        zero_d   = (quick_res == '0);
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            CALC: begin
                acc_d   = acc_step;
                x_d     = x_step;
                y_d     = y_step;
                count_d = count_q - 1'b1;
                if (count_q == CNT_W'(1)) begin
                    result_d = final_res;
                    zero_d   = (final_res == '0);
                    done_d   = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Control and architectural outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    // Engine datapath; always reloaded before use, so no reset needed
    always_ff @(posedge clk) begin
        mul_q <= mul_d;
        neg_q <= neg_d;
        acc_q <= acc_d;
        x_q   <= x_d;
        y_q   <= y_d;
    end

    assign bus.result  = result_q;
    assign bus.zero    = zero_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.illegal = illegal_q;
endmodule
